// File: rtl/text_screen_pkg.sv
// Shared constants, command encodings and engine states
// for the text screen bulk-update engine.
package text_screen_pkg;

  localparam int SCREEN_COLUMNS    = 80;
  localparam int SCREEN_ROWS       = 25;
  localparam int SCREEN_CELLS      = SCREEN_COLUMNS * SCREEN_ROWS;
  localparam int SCREEN_ADDR_WIDTH = 11;
  localparam int CELL_WIDTH        = 16;

  localparam logic [1:0] CMD_NOP         = 2'd0;
  localparam logic [1:0] CMD_CLEAR       = 2'd1;
  localparam logic [1:0] CMD_SCROLL_UP   = 2'd2;
  localparam logic [1:0] CMD_SCROLL_DOWN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_FINISH
  } scroll_state_t;

endpackage

// File: rtl/text_screen_addr_walker.sv
// Loadable up/down address walker: dst, src=dst+/-offset, last flag.
// Ports: clk, rst_n, load/start/stop/down, offset, step, stall, dst, src, last.
module text_screen_addr_walker #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] stop,
  input  logic          down,
  input  logic [AW-1:0] offset,
  input  logic          step,
  input  logic          stall,
  output logic [AW-1:0] dst,
  output logic [AW-1:0] src,
  output logic          last
);

  logic [AW-1:0] cur;
  logic [AW-1:0] stop_q;
  logic          down_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      stop_q <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      cur    <= start;
      stop_q <= stop;
      down_q <= down;
    end else if (step && !stall) begin
      cur <= down_q ? cur - 1'b1 : cur + 1'b1;
    end
  end

  assign dst  = cur;
  assign src  = down_q ? cur - offset : cur + offset;
  // exact-match terminal: the walker never steps past stop
  assign last = (cur == stop_q);

endmodule

// File: rtl/text_screen_scroll_engine.sv
// CLEAR / SCROLL_UP / SCROLL_DOWN engine on text RAM port B.
// Ports: cmd handshake, busy/done, granted RAM port B.
module text_screen_scroll_engine
  import text_screen_pkg::*;
#(
  parameter int COLUMNS    = SCREEN_COLUMNS,
  parameter int ROWS       = SCREEN_ROWS,
  parameter int ADDR_WIDTH = SCREEN_ADDR_WIDTH,
  parameter int DATA_WIDTH = CELL_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [1:0]            cmdOp,
  input  logic [DATA_WIDTH-1:0] fillWord,
  output logic                  busy,
  output logic                  done,
  input  logic                  ramGrant,
  output logic                  ramEnable,
  output logic                  ramWriteEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramWriteData,
  input  logic [DATA_WIDTH-1:0] ramReadData
);

  localparam int CELLS = COLUMNS * ROWS;
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(CELLS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_COLS = ADDR_WIDTH'(COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] A_LROW = ADDR_WIDTH'(CELLS - COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] A_UPEND = ADDR_WIDTH'(CELLS - COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ROW0E = ADDR_WIDTH'(COLUMNS - 1);

  scroll_state_t state, state_nxt;

  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [DATA_WIDTH-1:0] cap_q;

  logic                  ld;
  logic                  ld_down;
  logic [ADDR_WIDTH-1:0] ld_start;
  logic [ADDR_WIDTH-1:0] ld_stop;
  logic                  step;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] src;
  logic                  last;
  logic                  ram_en;
  logic                  ram_we;

  text_screen_addr_walker #(
    .AW(ADDR_WIDTH)
  ) u_walker (
    .clk   (clock),
    .rst_n (resetN),
    .load  (ld),
    .start (ld_start),
    .stop  (ld_stop),
    .down  (ld_down),
    .offset(A_COLS),
    .step  (step),
    .stall (!ramGrant),
    .dst   (dst),
    .src   (src),
    .last  (last)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= ST_IDLE;
      op_q   <= CMD_NOP;
      fill_q <= '0;
      cap_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cmdValid) begin
        op_q   <= cmdOp;
        fill_q <= fillWord;
      end
      // read was issued last cycle; data is valid now
      if (state == ST_CAPTURE) cap_q <= ramReadData;
    end
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_down   = 1'b0;
    ld_start  = '0;
    ld_stop   = '0;
    step      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmdValid) begin
          unique case (cmdOp)
            CMD_CLEAR: begin
              ld        = 1'b1;
              ld_stop   = A_LAST;
              state_nxt = ST_FILL;
            end
            CMD_SCROLL_UP: begin
              ld        = 1'b1;
              ld_stop   = A_UPEND;
              state_nxt = ST_READ;
            end
            CMD_SCROLL_DOWN: begin
              ld        = 1'b1;
              ld_start  = A_LAST;
              ld_stop   = A_COLS;
              ld_down   = 1'b1;
              state_nxt = ST_READ;
            end
            default: state_nxt = ST_FINISH;
          endcase
        end
      end
      ST_READ: begin
        ram_en = ramGrant;
        if (ramGrant) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = ST_WRITE;
      ST_WRITE: begin
        ram_en = ramGrant;
        ram_we = ramGrant;
        step   = !last;
        if (ramGrant) begin
          if (last) begin
            // reuse the walker for the vacated row
            ld        = 1'b1;
            ld_start  = (op_q == CMD_SCROLL_UP) ? A_LROW : '0;
            ld_stop   = (op_q == CMD_SCROLL_UP) ? A_LAST : A_ROW0E;
            state_nxt = ST_FILL;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_FILL: begin
        ram_en = ramGrant;
        ram_we = ramGrant;
        step   = !last;
        if (ramGrant && last) state_nxt = ST_FINISH;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign cmdReady       = (state == ST_IDLE);
  assign done           = (state == ST_FINISH);
  assign busy           = !(state == ST_IDLE) &&
                          !(state == ST_FINISH && op_q == CMD_NOP);
  assign ramEnable      = ram_en;
  assign ramWriteEnable = ram_we;
  assign ramAddress     = (state == ST_READ) ? src : dst;
  assign ramWriteData   = (state == ST_WRITE) ? cap_q : fill_q;

endmodule

// File: tb/tb_text_screen_scroll_engine.sv
// Self-checking bench for text_screen_scroll_engine:
// RAM model, expected-access queue model and literal pins.
module tb_text_screen_scroll_engine;

  logic        clock = 1'b0;
  logic        resetN;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [15:0] fillWord;
  logic        busy;
  logic        done;
  logic        ramGrant;
  logic        ramEnable;
  logic        ramWriteEnable;
  logic [10:0] ramAddress;
  logic [15:0] ramWriteData;
  logic [15:0] ramReadData;

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [15:0] data;
  } acc_t;

  logic [15:0] mem [0:2047];
  logic [15:0] up_ref [0:2047];
  logic [15:0] rd_q;
  acc_t        exp_q[$];
  logic        preload_go = 1'b0;
  logic        grant_rand = 1'b0;
  int          checks = 0;
  int          failures = 0;

  text_screen_scroll_engine dut (
    .clock         (clock),
    .resetN        (resetN),
    .cmdValid      (cmdValid),
    .cmdReady      (cmdReady),
    .cmdOp         (cmdOp),
    .fillWord      (fillWord),
    .busy          (busy),
    .done          (done),
    .ramGrant      (ramGrant),
    .ramEnable     (ramEnable),
    .ramWriteEnable(ramWriteEnable),
    .ramAddress    (ramAddress),
    .ramWriteData  (ramWriteData),
    .ramReadData   (ramReadData)
  );

  always #5 clock = ~clock;

  assign ramReadData = rd_q;

  always @(posedge clock) begin
    if (preload_go) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'(i);
    end else if (ramEnable && ramGrant) begin
      if (ramWriteEnable) mem[ramAddress] <= ramWriteData;
      else rd_q <= mem[ramAddress];
    end
  end

  initial begin
    ramGrant = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      ramGrant = grant_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic we, input int a,
                              input logic [15:0] d);
    acc_t r;
    r.we = we;
    r.addr = 11'(a);
    r.data = d;
    return r;
  endfunction

  // every granted access must be the next one the model predicts
  initial begin
    acc_t e;
    int   pend;
    forever begin
      @(negedge clock);
      if (ramWriteEnable) chk("we_without_en", 32'(ramEnable), 32'd1);
      if (resetN && ramEnable) begin
        chk("en_without_grant", 32'(ramGrant), 32'd1);
        chk("addr_range", 32'(ramAddress < 11'd2000), 32'd1);
        pend = exp_q.size();
        e = (pend > 0) ? exp_q.pop_front() : '0;
        chk("access_expected", 32'(pend > 0), 32'd1);
        chk("access",
            {4'h0, ramWriteEnable, ramAddress,
             ramWriteEnable ? ramWriteData : 16'h0},
            {4'h0, e.we, e.addr, e.we ? e.data : 16'h0});
      end
    end
  end

  task automatic build_exp(input logic [1:0] op, input logic [15:0] fw);
    exp_q.delete();
    if (op == 2'd1) begin
      for (int a = 0; a < 2000; a++) exp_q.push_back(mk(1'b1, a, fw));
    end else if (op == 2'd2) begin
      for (int d = 0; d < 1920; d++) begin
        exp_q.push_back(mk(1'b0, d + 80, 16'h0));
        exp_q.push_back(mk(1'b1, d, mem[d+80]));
      end
      for (int a = 1920; a < 2000; a++) exp_q.push_back(mk(1'b1, a, fw));
    end else if (op == 2'd3) begin
      for (int d = 1999; d >= 80; d--) begin
        exp_q.push_back(mk(1'b0, d - 80, 16'h0));
        exp_q.push_back(mk(1'b1, d, mem[d-80]));
      end
      for (int a = 0; a < 80; a++) exp_q.push_back(mk(1'b1, a, fw));
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] fw);
    @(negedge clock);
    cmdOp = op;
    fillWord = fw;
    cmdValid = 1'b1;
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    cmdOp = 2'd0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] fw,
                         input int exp_n);
    int n;
    bit got;
    build_exp(op, fw);
    issue(op, fw);
    n = 0;
    got = 0;
    while (n < 30000 && !got) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("busy_first", 32'(busy), 32'(op != 2'd0));
      if (n == 2 && op != 2'd0)
        chk("ready_low", 32'(cmdReady), 32'd0);
      if (done) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (exp_n > 0) chk("done_cycle", 32'(n), 32'(exp_n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_ready", {30'd0, cmdReady, busy}, 32'd2);
  endtask

  task automatic preload();
    @(negedge clock);
    preload_go = 1'b1;
    @(posedge clock);
    #1;
    preload_go = 1'b0;
  endtask

  initial begin
    int bad;
    int wr;
    resetN = 1'b0;
    cmdValid = 1'b0;
    cmdOp = 2'd0;
    fillWord = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(cmdReady), 32'd1);
    chk("rst_flags", {29'd0, busy, done, ramEnable}, 32'd0);
    chk("rst_we", 32'(ramWriteEnable), 32'd0);
    chk("rst_addr", 32'(ramAddress), 32'd0);
    chk("rst_wdata", 32'(ramWriteData), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    preload();
    run_cmd(2'd1, 16'h0720, 2001);
    chk("clr_0", 32'(mem[0]), 32'h0720);
    chk("clr_1999", 32'(mem[1999]), 32'h0720);
    chk("clr_2000", 32'(mem[2000]), 32'd2000);

    preload();
    run_cmd(2'd2, 16'h0000, 5841);
    chk("up_0", 32'(mem[0]), 32'd80);
    chk("up_1919", 32'(mem[1919]), 32'd1999);
    bad = 0;
    for (int i = 1920; i < 2000; i++) if (mem[i] != 16'h0) bad++;
    chk("up_lastrow", 32'(bad), 32'd0);
    chk("up_2000", 32'(mem[2000]), 32'd2000);
    for (int i = 0; i < 2048; i++) up_ref[i] = mem[i];

    preload();
    run_cmd(2'd3, 16'hFFFF, 5841);
    chk("dn_1999", 32'(mem[1999]), 32'd1919);
    chk("dn_80", 32'(mem[80]), 32'd0);
    bad = 0;
    for (int i = 0; i < 80; i++) if (mem[i] != 16'hFFFF) bad++;
    chk("dn_row0", 32'(bad), 32'd0);
    chk("dn_2047", 32'(mem[2047]), 32'd2047);

    preload();
    grant_rand = 1'b1;
    run_cmd(2'd2, 16'h0000, 0);
    grant_rand = 1'b0;
    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== up_ref[i]) bad++;
    chk("stall_ram", 32'(bad), 32'd0);

    preload();
    build_exp(2'd1, 16'h1234);
    issue(2'd1, 16'h1234);
    wr = 0;
    for (int c = 0; c < 500 && wr < 100; c++) begin
      @(negedge clock);
      if (ramEnable && ramWriteEnable) wr++;
    end
    chk("mid_writes", 32'(wr), 32'd100);
    @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    chk("mid_ready", 32'(cmdReady), 32'd1);
    chk("mid_flags", {29'd0, busy, done, ramEnable}, 32'd0);
    chk("mid_addr", {4'h0, ramWriteEnable, ramAddress, ramWriteData},
        32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    chk("mid_0", 32'(mem[0]), 32'h1234);
    chk("mid_99", 32'(mem[99]), 32'h1234);
    chk("mid_100", 32'(mem[100]), 32'd100);
    chk("mid_1999", 32'(mem[1999]), 32'd1999);
    resetN = 1'b1;
    run_cmd(2'd1, 16'h0720, 2001);
    chk("reclr_500", 32'(mem[500]), 32'h0720);

    run_cmd(2'd0, 16'hBEEF, 1);
    repeat (5) @(negedge clock);
    chk("nop_2000", 32'(mem[2000]), 32'd2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
